park_controller: RTL and testbench

PARK_CONTROLLER -- requirements
Module: park_controller

---
 rtl/park_controller.sv | 199 +++++++++++++++++++
 tb/tb_park_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/park_controller.sv
// Eight-slot parking controller: slot allocation with issued patterns, verified exits.
// Optional exit lockout after three consecutive failed exits is enabled by PARK_LOCKOUT_EN.
module park_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [2:0] exit_token,
  input  logic [2:0] exit_pattern,
  output logic       grant,
  output logic       deny,
  output logic [2:0] grant_token,
  output logic [2:0] grant_pattern,
  output logic [7:0] park_location,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALLOC = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
`ifdef PARK_LOCKOUT_EN
  localparam logic [2:0] S_LOCK  = 3'd4;
`endif

  logic [2:0] state_q, state_d;
  logic [2:0] slot_pat_q [8];
  logic [2:0] slot_pat_d [8];
  logic [7:0] occ_q, occ_d;
  logic [2:0] pat_cnt_q, pat_cnt_d;
  logic [2:0] tok_q, tok_d;
  logic [2:0] epat_q, epat_d;
  logic       grant_q, grant_d;
  logic       deny_q, deny_d;
  logic [2:0] gtok_q, gtok_d;
  logic [2:0] gpat_q, gpat_d;
  logic [7:0] loc_q, loc_d;
  logic [3:0] free_q, free_d;
  logic       full_q, full_d;
`ifdef PARK_LOCKOUT_EN
  logic [1:0] fail_q, fail_d;
  logic [3:0] lock_q, lock_d;
`endif

  logic       found;
  logic [2:0] free_idx;
  logic [3:0] pop;

  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!occ_q[i] && !found) begin
        found    = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_pat_d = slot_pat_q;
    occ_d      = occ_q;
    pat_cnt_d  = pat_cnt_q;
    tok_d      = tok_q;
    epat_d     = epat_q;
    grant_d    = 1'b0;
    deny_d     = 1'b0;
    gtok_d     = '0;
    gpat_d     = '0;
    loc_d      = '0;
`ifdef PARK_LOCKOUT_EN
    fail_d     = fail_q;
    lock_d     = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (exit_req) begin
          tok_d   = exit_token;
          epat_d  = exit_pattern;
          state_d = S_CHECK;
        end else if (enter_req) begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (found) begin
          occ_d[free_idx]      = 1'b1;
          slot_pat_d[free_idx] = pat_cnt_q;
          pat_cnt_d            = pat_cnt_q + 3'd1;
          grant_d              = 1'b1;
          gtok_d               = free_idx;
          gpat_d               = pat_cnt_q;
        end else begin
          deny_d = 1'b1;
        end
        state_d = S_RESP;
      end
      S_CHECK: begin
        if (occ_q[tok_q] && (slot_pat_q[tok_q] == epat_q)) begin
          occ_d[tok_q] = 1'b0;
          grant_d      = 1'b1;
          loc_d        = 8'd1 << tok_q;
`ifdef PARK_LOCKOUT_EN
          fail_d       = '0;
`endif
        end else begin
          deny_d = 1'b1;
`ifdef PARK_LOCKOUT_EN
          fail_d = fail_q + 2'd1;
`endif
        end
        state_d = S_RESP;
      end
      S_RESP: begin
`ifdef PARK_LOCKOUT_EN
        // fail_q reaches 3 only on the third consecutive exit deny
        state_d = (fail_q == 2'd3) ? S_LOCK : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef PARK_LOCKOUT_EN
      S_LOCK: begin
        lock_d = lock_q + 4'd1;
        if (lock_q == 4'd15) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + {3'b000, occ_d[i]};
    end
    free_d = 4'd8 - pop;
    full_d = (occ_d == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      slot_pat_q <= '{default: '0};
      occ_q      <= '0;
      pat_cnt_q  <= '0;
      tok_q      <= '0;
      epat_q     <= '0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      gtok_q     <= '0;
      gpat_q     <= '0;
      loc_q      <= '0;
      free_q     <= 4'd8;
      full_q     <= 1'b0;
`ifdef PARK_LOCKOUT_EN
      fail_q     <= '0;
      lock_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_pat_q <= slot_pat_d;
      occ_q      <= occ_d;
      pat_cnt_q  <= pat_cnt_d;
      tok_q      <= tok_d;
      epat_q     <= epat_d;
      grant_q    <= grant_d;
      deny_q     <= deny_d;
      gtok_q     <= gtok_d;
      gpat_q     <= gpat_d;
      loc_q      <= loc_d;
      free_q     <= free_d;
      full_q     <= full_d;
`ifdef PARK_LOCKOUT_EN
      fail_q     <= fail_d;
      lock_q     <= lock_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign deny          = deny_q;
  assign grant_token   = gtok_q;
  assign grant_pattern = gpat_q;
  assign park_location = loc_q;
  assign occupancy     = occ_q;
  assign free_count    = free_q;
  assign full          = full_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_park_controller.sv
// Directed and randomized checks of park_controller against a slot-table reference model.
module tb_park_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_token = '0;
  logic [2:0] exit_pattern = '0;
  logic       grant, deny, full, busy;
  logic [2:0] grant_token, grant_pattern;
  logic [7:0] park_location, occupancy;
  logic [3:0] free_count;

  park_controller dut (
    .clk(clk), .rst(rst), .enter_req(enter_req), .exit_req(exit_req),
    .exit_token(exit_token), .exit_pattern(exit_pattern),
    .grant(grant), .deny(deny), .grant_token(grant_token), .grant_pattern(grant_pattern),
    .park_location(park_location), .occupancy(occupancy), .free_count(free_count),
    .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit         m_occ [8];
  logic [2:0] m_pat [8];
  logic [2:0] m_cnt;
  int         m_fail;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] m_occ_byte();
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b[i] = m_occ[i];
    return b;
  endfunction

  function automatic logic [3:0] m_free();
    int n = 8;
    for (int i = 0; i < 8; i++) if (m_occ[i]) n--;
    return 4'(n);
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".occ"}, occupancy, m_occ_byte());
    chk({tag, ".free"}, {4'b0, free_count}, {4'b0, m_free()});
    chk({tag, ".full"}, {7'b0, full}, {7'b0, (m_occ_byte() == 8'hFF)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin m_occ[i] = 1'b0; m_pat[i] = '0; end
    m_cnt  = '0;
    m_fail = 0;
    chk("rst.grant", {7'b0, grant}, 8'd0);
    chk("rst.deny", {7'b0, deny}, 8'd0);
    chk("rst.loc", park_location, 8'd0);
    chk("rst.busy", {7'b0, busy}, 8'd0);
    check_status("rst");
  endtask

  // One request transaction starting from IDLE; expectations come from the model first.
  task automatic op(input bit en, input bit ex, input logic [2:0] tok, input logic [2:0] patt);
    bit         g = 1'b0;
    bit         lock = 1'b0;
    logic [2:0] gt = '0, gp = '0;
    logic [7:0] loc = '0;
    logic [7:0] one = 8'd1;
    if (ex) begin
      if (m_occ[tok] && m_pat[tok] == patt) begin
        g = 1'b1;
        m_occ[tok] = 1'b0;
        loc = one << tok;
        m_fail = 0;
      end else begin
        m_fail++;
      end
`ifdef PARK_LOCKOUT_EN
      if (m_fail == 3) begin lock = 1'b1; m_fail = 0; end
`endif
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!g && !m_occ[i]) begin
          g = 1'b1; gt = 3'(i); gp = m_cnt;
          m_occ[i] = 1'b1; m_pat[i] = m_cnt; m_cnt = m_cnt + 3'd1;
        end
      end
    end
    enter_req = en; exit_req = ex; exit_token = tok; exit_pattern = patt;
    @(posedge clk); #1;
    enter_req = 1'b0; exit_req = 1'b0;
    chk("acc.busy", {7'b0, busy}, 8'd1);
    chk("acc.grant", {7'b0, grant}, 8'd0);
    @(posedge clk); #1;
    chk("resp.grant", {7'b0, grant}, {7'b0, g});
    chk("resp.deny", {7'b0, deny}, {7'b0, !g});
    chk("resp.gtok", {5'b0, grant_token}, {5'b0, gt});
    chk("resp.gpat", {5'b0, grant_pattern}, {5'b0, gp});
    chk("resp.loc", park_location, loc);
    check_status("resp");
    @(posedge clk); #1;
    chk("post.grant", {7'b0, grant}, 8'd0);
    chk("post.deny", {7'b0, deny}, 8'd0);
    if (lock) begin
      // hold a request that would be valid during the whole lockout
      exit_req = 1'b1; enter_req = 1'b1; exit_token = '0; exit_pattern = m_pat[0];
      chk("lock.busy0", {7'b0, busy}, 8'd1);
      for (int i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        chk("lock.busy", {7'b0, busy}, 8'd1);
        chk("lock.grant", {7'b0, grant | deny}, 8'd0);
      end
      @(posedge clk); #1;
      exit_req = 1'b0; enter_req = 1'b0;
      check_status("lock");
    end
    chk("post.busy", {7'b0, busy}, 8'd0);
  endtask

  initial begin
    do_reset();

    // first entry
    op(1'b1, 1'b0, '0, '0);
    // fill remaining slots, then one more entry is denied
    for (int i = 1; i < 8; i++) op(1'b1, 1'b0, '0, '0);
    chk("fill.full", {7'b0, full}, 8'd1);
    op(1'b1, 1'b0, '0, '0);

    // exit of slot 2 with correct pattern, then the same exit again
    do_reset();
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, '0, '0);
    op(1'b0, 1'b1, 3'd2, 3'd2);
    op(1'b0, 1'b1, 3'd2, 3'd2);

    // simultaneous enter and exit: exit wins, entry is dropped
    do_reset();
    op(1'b1, 1'b0, '0, '0);
    op(1'b1, 1'b1, 3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drop.busy", {7'b0, busy}, 8'd0);
    check_status("drop");

    // reset during CHECK discards the response
    op(1'b1, 1'b0, '0, '0);
    exit_req = 1'b1; exit_token = 3'd0; exit_pattern = 3'd1;
    @(posedge clk); #1;
    exit_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.grant", {7'b0, grant}, 8'd0);
    chk("midrst.deny", {7'b0, deny}, 8'd0);
    chk("midrst.occ", occupancy, 8'd0);
    chk("midrst.free", {4'b0, free_count}, 8'd8);
    @(posedge clk); #1;
    chk("midrst.pulse", {7'b0, grant | deny}, 8'd0);
    do_reset();

    // three wrong-pattern exits in a row
    op(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 3'd0, 3'd5);
    op(1'b0, 1'b1, 3'd0, 3'd0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 120; n++) begin
      logic [2:0] t, p;
      int         kind;
      kind = int'($urandom_range(0, 9));
      t    = 3'($urandom_range(0, 7));
      p    = ($urandom_range(0, 2) != 0) ? m_pat[t] : 3'($urandom_range(0, 7));
      if (kind < 5)       op(1'b1, 1'b0, t, p);
      else if (kind < 9)  op(1'b0, 1'b1, t, p);
      else                op(1'b1, 1'b1, t, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
